// File: rtl/bcd_sevenseg_scanner.sv
// Eight-digit multiplexed seven-segment driver for a packed BCD bus.
// Snapshots the input once per frame, blanks leading zeros, and shows a dash for non-BCD nibbles.
module bcd_sevenseg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] BCD_number,
    input  logic [7:0]  dp_mask,
    input  logic        blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] PRESCALE_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] prescale_reg;
    logic [2:0]    digit_idx_reg;
    logic [31:0]   shadow_bcd_reg;
    logic [7:0]    shadow_dp_reg;
    logic [7:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_done_reg;

    logic          tick;
    logic [7:0]    digit_sig;
    logic [7:0]    digit_lit;
    logic [3:0]    cur_nibble;
    logic [6:0]    seg_decoded;
    logic          show;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign tick = (prescale_reg == PRESCALE_LAST);

    // A digit stays lit if it or any more significant digit carries a nonzero value or a decimal point.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_sig[gi] = (shadow_bcd_reg[4*gi +: 4] != 4'd0) || shadow_dp_reg[gi];
            if (gi == 0) begin : g_lsd
                assign digit_lit[gi] = 1'b1;
            end else if (LZ_BLANK) begin : g_lz
                assign digit_lit[gi] = |digit_sig[7:gi];
            end else begin : g_all
                assign digit_lit[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        cur_nibble = shadow_bcd_reg[{digit_idx_reg, 2'b00} +: 4];
        case (cur_nibble)
            4'd0:    seg_decoded = 7'b1000000;
            4'd1:    seg_decoded = 7'b1111001;
            4'd2:    seg_decoded = 7'b0100100;
            4'd3:    seg_decoded = 7'b0110000;
            4'd4:    seg_decoded = 7'b0011001;
            4'd5:    seg_decoded = 7'b0010010;
            4'd6:    seg_decoded = 7'b0000010;
            4'd7:    seg_decoded = 7'b1111000;
            4'd8:    seg_decoded = 7'b0000000;
            4'd9:    seg_decoded = 7'b0010000;
            default: seg_decoded = 7'b0111111;
        endcase
    end

    always_comb begin
        show     = digit_lit[digit_idx_reg] && !blank;
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (show) begin
            an_next  = ~(8'd1 << digit_idx_reg);
            seg_next = seg_decoded;
            dp_next  = ~shadow_dp_reg[digit_idx_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_reg   <= '0;
            digit_idx_reg  <= 3'd7;
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
            an_reg         <= 8'hFF;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (tick) begin
                prescale_reg  <= '0;
                digit_idx_reg <= digit_idx_reg + 3'd1;
                // Wrapping 7 -> 0 starts a new frame from a fresh copy of the inputs.
                if (digit_idx_reg == 3'd7) begin
                    shadow_bcd_reg <= BCD_number;
                    shadow_dp_reg  <= dp_mask;
                    frame_done_reg <= 1'b1;
                end
            end else begin
                prescale_reg <= prescale_reg + CW'(1);
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/bcd_sevenseg_scanner.md
Name: bcd_sevenseg_scanner

Overview:
- Downstream consumer of the 32-bit, 8-digit packed BCD bus produced by the binary-to-BCD converter.
- Time-multiplexes the eight digits onto a shared active-low seven-segment bus with per-digit anode enables.
- Adds leading-zero blanking, per-digit decimal points, a global blank, and a dash for invalid nibbles.
- Input is snapshotted once per frame so the display never shows a torn value.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit, 125 Hz frame); legal range >= 2.
LZ_BLANK, 1, 1 = suppress leading zeros; 0 = show all eight digits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
BCD_number  input  32  packed BCD, digit k = BCD_number[4k+3:4k], k=0 least significant
dp_mask  input  8  bit k = 1 lights decimal point of digit k
blank  input  1  1 = all anodes off, scanning continues
an  output  8  active-low anode enables, an[k] drives digit k
seg  output  7  active-low cathodes {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point
frame_done  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, immediate): prescaler=0, digit_idx=7, shadow_bcd=0, shadow_dp=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Prescaler counts 0..REFRESH_DIV-1. tick=1 in the cycle where count==REFRESH_DIV-1; count then wraps to 0.
- On tick, digit_idx advances modulo 8 (7 -> 0).
- Snapshot: on a tick where digit_idx==7, shadow_bcd<=BCD_number and shadow_dp<=dp_mask at the same edge that digit_idx becomes 0.
  - frame_done is registered and is 1 for exactly the cycle after that edge.
  - The first tick after reset release therefore loads the first snapshot.
- Input changes between snapshots have no visible effect.
- an/seg/dp are registered from the current digit_idx and the shadow registers, so they lag digit_idx by one cycle.
- Exactly one an bit is low at a time. That bit is an[digit_idx], and only if the digit is displayed.
- Segment decode, nibble -> seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A..F = 0111111 (dash, g only)
- Leading-zero blanking (LZ_BLANK=1): digit k>=1 is blanked iff every shadow digit j>=k is 0 and every shadow_dp[j] for j>=k is 0.
  - Digit 0 is never blanked.
  - Blanked digit: an all 1, seg=7'h7F, dp=1.
- dp = ~shadow_dp[digit_idx] when the digit is displayed, else 1.
- blank: sampled each cycle. When 1, the next output update forces an=8'hFF, seg=7'h7F, dp=1.
  - Prescaler, digit_idx and snapshotting continue unaffected.
- Simultaneous events:
  - reset overrides everything.
  - blank and tick in the same cycle: digit_idx still advances; outputs forced off.
- Reset mid-frame: the partially displayed frame is discarded; the next snapshot follows the normal first-tick rule.
- Frame period = 8*REFRESH_DIV cycles; frame_done period is identical.

Test Plan:
(All scenarios use REFRESH_DIV=4, LZ_BLANK=1.)
1. Reset and first frame: assert reset mid-scan -> an=FF, seg=7F, dp=1 in the same cycle, without a clock edge. Release with BCD_number=32'h00012345 -> frame_done pulses 5 cycles after release (first tick in cycle 4, registered pulse one cycle later). Then:
   - slot 0: an=11111110, seg=0010010
   - slot 1: seg=0011001
   - slot 4: seg=1111001
   - slots 5-7: an stays FF
   - frame_done repeats every 32 cycles.
2. Zero and decimal point:
   - BCD_number=0 -> only digit 0 lit, seg=1000000.
   - BCD_number=32'h00000005, dp_mask=8'h04 -> digits 0,1,2 show 5,0,0; dp=0 only while an[2]=0; digits 3-7 dark.
3. Invalid nibble: BCD_number=32'h0000A0F1 -> digits 1 and 3 show 0111111, digit 2 shows 1000000, digit 0 shows 1111001.
4. Snapshot isolation: change BCD_number from 32'h11111111 to 32'h22222222 while digit_idx=3 -> remaining slots of that frame still show 1111001; 2s (0100100) appear only after the next frame_done.
5. Blank and LZ_BLANK=0:
   - blank=1 for 20 cycles -> an=FF throughout; digit_idx keeps cycling; frame_done cadence unchanged.
   - Re-run scenario 1's input with LZ_BLANK=0 -> digits 5-7 lit showing 1000000.
